// File: rtl/pipeline_defs.sv
// Shared fetch/decode pipeline definitions.
package pipeline_defs;

    localparam int unsigned IF_ID_XLEN  = 64;
    localparam int unsigned IF_ID_ILEN  = 32;
    localparam int unsigned IF_ID_DEPTH = 2;

    // One fetched word as it travels from fetch to decode.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
        logic        done;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_stage_buffer.sv
// Fetch->decode stage buffer: DEPTH-entry in-order queue with valid/ready on both sides,
// flush on redirect, and a saturating count of decode-starved cycles.
module if_id_stage_buffer
    import pipeline_defs::*;
#(
    parameter int unsigned XLEN  = IF_ID_XLEN,
    parameter int unsigned ILEN  = IF_ID_ILEN,
    parameter int unsigned DEPTH = IF_ID_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [ILEN-1:0]            in_instruction,
    input  logic                       in_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_instruction,
    output logic                       out_done,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [31:0]                starve_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH+1);

    if_id_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [OW-1:0]  occ_q, occ_d;
    logic [31:0]    starve_q, starve_d;

    logic           push;
    logic           pop;
    if_id_entry_t   wr_entry;
    if_id_entry_t   head_entry;

    // Handshake qualification; ready/valid come only from registered occupancy.
    always_comb begin
        in_ready  = (occ_q != OW'(DEPTH));
        out_valid = (occ_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        wr_entry             = '0;
        wr_entry.pc          = in_pc;
        wr_entry.instruction = in_instruction;
        wr_entry.done        = in_done;
    end

    // Next-state for pointers, occupancy and starve counter; flush overrides push/pop.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        occ_d    = occ_q;
        starve_d = starve_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            if (push && !pop)      occ_d = occ_q + OW'(1);
            else if (pop && !push) occ_d = occ_q - OW'(1);
        end
        if (out_ready && !out_valid && !flush && (starve_q != '1)) begin
            starve_d = starve_q + 32'd1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            occ_q    <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage; contents are don't-care while not counted by occupancy.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= wr_entry;
    end

    // Head presentation: zeros when empty so decode sees a clean bubble.
    always_comb begin
        head_entry      = out_valid ? mem_q[head_q] : '0;
        out_pc          = XLEN'(head_entry.pc);
        out_instruction = ILEN'(head_entry.instruction);
        out_done        = head_entry.done;
        occupancy       = occ_q;
        starve_count    = starve_q;
    end

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Self-checking bench for if_id_stage_buffer: directed vector table, async reset,
// starve saturation, and randomized traffic against a queue-based reference model.
module tb_if_id_stage_buffer;
    import pipeline_defs::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instruction;
    logic        in_done;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_done;
    logic [1:0]  occupancy;
    logic [31:0] starve_count;

    if_id_stage_buffer #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .in_done         (in_done),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_done        (out_done),
        .occupancy       (occupancy),
        .starve_count    (starve_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain FIFO of entries plus a starve tally.
    if_id_entry_t mq[$];
    logic [31:0]  m_starve;

    typedef struct {
        bit          fl;
        bit          iv;
        bit          ordy;
        logic [63:0] pc;
        logic [31:0] ins;
        bit          dn;
        bit          e_ov;
        bit          e_ir;
        int          e_occ;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        bit          e_dn;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(bit fl, bit iv, bit ordy, logic [63:0] pc, logic [31:0] ins,
                                bit dn, bit e_ov, bit e_ir, int e_occ, logic [63:0] e_pc,
                                logic [31:0] e_ins, bit e_dn);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.ins = ins; v.dn = dn;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_pc = e_pc; v.e_ins = e_ins;
        v.e_dn = e_dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model's current state.
    task automatic chk_model(input string tag);
        if_id_entry_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
        chk({tag, ".starve"}, 64'(starve_count), 64'(m_starve));
        chk({tag, ".out_pc"}, out_pc, h.pc);
        chk({tag, ".out_instr"}, 64'(out_instruction), 64'(h.instruction));
        chk({tag, ".out_done"}, 64'(out_done), 64'(h.done));
    endtask

    // Apply one cycle of inputs (called at negedge), advance model, check after the edge.
    task automatic step(input bit fl, input bit iv, input bit ordy, input logic [63:0] pc,
                        input logic [31:0] ins, input bit dn, input string tag);
        bit rdy, vld, do_push, do_pop;
        if_id_entry_t e;
        flush = fl; in_valid = iv; out_ready = ordy;
        in_pc = pc; in_instruction = ins; in_done = dn;
        rdy = (mq.size() != DEPTH);
        vld = (mq.size() != 0);
        do_push = iv && rdy && !fl;
        do_pop  = vld && ordy && !fl;
        if (ordy && !vld && !fl && m_starve != 32'hFFFF_FFFF) m_starve = m_starve + 1;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc = pc; e.instruction = ins; e.done = dn;
                mq.push_back(e);
            end
        end
        @(negedge clk);
        chk_model(tag);
    endtask

    initial begin
        bit           hold;
        logic [63:0]  r_pc;
        logic [31:0]  r_ins;
        bit           r_dn;
        bit           r_fl, r_iv, r_or, rdy;

        reset_n = 1'b0;
        flush = 0; in_valid = 0; out_ready = 0;
        in_pc = '0; in_instruction = '0; in_done = 0;
        m_starve = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_model("reset");

        tbl[0]  = mk(0,1,1,64'h1000,32'h00500093,0, 1,1,1,64'h1000,32'h00500093,0);
        tbl[1]  = mk(0,0,1,64'h0,   32'h0,       0, 0,1,0,64'h0,   32'h0,       0);
        tbl[2]  = mk(0,1,0,64'h1000,32'h00500093,0, 1,1,1,64'h1000,32'h00500093,0);
        tbl[3]  = mk(0,1,0,64'h1004,32'h00A00113,0, 1,0,2,64'h1000,32'h00500093,0);
        tbl[4]  = mk(0,1,0,64'h1008,32'h002081B3,1, 1,0,2,64'h1000,32'h00500093,0);
        tbl[5]  = mk(0,1,1,64'h1008,32'h002081B3,1, 1,1,1,64'h1004,32'h00A00113,0);
        tbl[6]  = mk(0,1,1,64'h1008,32'h002081B3,1, 1,1,1,64'h1008,32'h002081B3,1);
        tbl[7]  = mk(0,0,1,64'h0,   32'h0,       0, 0,1,0,64'h0,   32'h0,       0);
        tbl[8]  = mk(0,1,0,64'h2000,32'h11111111,1, 1,1,1,64'h2000,32'h11111111,1);
        tbl[9]  = mk(0,1,0,64'h2004,32'h22222222,0, 1,0,2,64'h2000,32'h11111111,1);
        tbl[10] = mk(1,1,1,64'h2008,32'h33333333,1, 0,1,0,64'h0,   32'h0,       0);
        tbl[11] = mk(0,0,0,64'h0,   32'h0,       0, 0,1,0,64'h0,   32'h0,       0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].pc, tbl[i].ins, tbl[i].dn,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.ov", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("vec%0d.ir", i), 64'(in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("vec%0d.occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
            chk($sformatf("vec%0d.pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d.ins", i), 64'(out_instruction), 64'(tbl[i].e_ins));
            chk($sformatf("vec%0d.dn", i), 64'(out_done), 64'(tbl[i].e_dn));
        end

        // Starve counting: five starved cycles add exactly five.
        r_pc = 64'(m_starve);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 64'h0, 32'h0, 0, "starve");
        chk("starve.plus5", 64'(starve_count), r_pc + 64'd5);

        // Saturation: preload near the top, then starve past it.
        out_ready = 1'b0;
        force dut.starve_q = 32'hFFFF_FFFE;
        #1;
        release dut.starve_q;
        m_starve = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 64'h0, 32'h0, 0, "sat");
        chk("starve.sat", 64'(starve_count), 64'hFFFF_FFFF);

        // Async reset mid-cycle with a partly filled buffer.
        step(0, 1, 0, 64'h3000, 32'h44444444, 1, "prerst0");
        step(0, 1, 0, 64'h3004, 32'h55555555, 0, "prerst1");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        m_starve = '0;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        chk("arst.occupancy", 64'(occupancy), 64'd0);
        chk("arst.starve", 64'(starve_count), 64'd0);
        chk("arst.out_pc", out_pc, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk_model("postrst");

        // Randomized traffic; producer holds its word while stalled.
        hold = 0;
        r_pc = '0; r_ins = '0; r_dn = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                r_pc  = {$urandom, $urandom};
                r_ins = $urandom;
                r_dn  = 1'($urandom_range(0, 1));
            end
            r_fl = ($urandom_range(0, 15) == 0);
            r_iv = hold ? 1'b1 : 1'($urandom_range(0, 1));
            r_or = ($urandom_range(0, 3) != 0);
            rdy  = (mq.size() != DEPTH);
            hold = r_iv && !rdy && !r_fl;
            step(r_fl, r_iv, r_or, r_pc, r_ins, r_dn, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench never hangs.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
